// File: rtl/uisetvbuf_wctrl_if.sv
// Control/handshake bundle between the video-side write controller and its DMA write engine.
// The slave modport is the controller's view; the master modport is the driver's view.
interface uisetvbuf_wctrl_if;
  logic        I_en;
  logic        I_fs;
  logic        I_wr_ack;
  logic        I_wr_done;
  logic        O_wr_req;
  logic [7:0]  O_bufn;
  logic        O_bufn_upd;
  logic [15:0] O_frame_cnt;
  logic [15:0] O_ovr_cnt;
  logic        O_timeout;

  modport slave (
    input  I_en, I_fs, I_wr_ack, I_wr_done,
    output O_wr_req, O_bufn, O_bufn_upd, O_frame_cnt, O_ovr_cnt, O_timeout
  );

  modport master (
    output I_en, I_fs, I_wr_ack, I_wr_done,
    input  O_wr_req, O_bufn, O_bufn_upd, O_frame_cnt, O_ovr_cnt, O_timeout
  );
endinterface

// File: rtl/uisetvbuf_wctrl.sv
// Write-side frame-buffer index manager: one DMA frame write per frame start, index advances
// modulo BUF_LENTH on completion, with overrun counting and a done watchdog.
module uisetvbuf_wctrl #(
  parameter int unsigned BUF_LENTH      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2**24,
  parameter bit          FS_POL         = 1'b1
) (
  input  logic                 I_clk,
  input  logic                 I_rstn,
  uisetvbuf_wctrl_if.slave     bus
);

  localparam int unsigned WD_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      BUF_LAST = 8'(BUF_LENTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FS,
    S_REQ,
    S_WAIT_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            fs_d;
  logic            fs_edge;
  logic [WD_W-1:0] watchdog;
  logic [7:0]      bufn;
  logic            bufn_upd;
  logic [15:0]     frame_cnt;
  logic [15:0]     ovr_cnt;
  logic            timeout;

  logic            commit;
  logic            expire;
  logic            ovr_hit;
  logic            wd_clr;

  assign fs_edge = FS_POL ? (bus.I_fs & ~fs_d) : (~bus.I_fs & fs_d);

  always_ff @(posedge I_clk) begin
    if (!I_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Done takes priority over watchdog expiry; frame starts while busy are only counted.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    expire    = 1'b0;
    ovr_hit   = 1'b0;
    wd_clr    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.I_en) state_nxt = S_WAIT_FS;
      end
      S_WAIT_FS: begin
        if (!bus.I_en)    state_nxt = S_IDLE;
        else if (fs_edge) state_nxt = S_REQ;
      end
      S_REQ: begin
        ovr_hit = fs_edge;
        if (bus.I_wr_ack) begin
          wd_clr    = 1'b1;
          state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        ovr_hit = fs_edge;
        if (bus.I_wr_done) begin
          commit    = 1'b1;
          state_nxt = bus.I_en ? S_WAIT_FS : S_IDLE;
        end else if (watchdog == WD_LAST) begin
          expire    = 1'b1;
          state_nxt = bus.I_en ? S_WAIT_FS : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_rstn) begin
      fs_d      <= 1'b0;
      watchdog  <= '0;
      bufn      <= '0;
      bufn_upd  <= 1'b0;
      frame_cnt <= '0;
      ovr_cnt   <= '0;
      timeout   <= 1'b0;
    end else begin
      fs_d     <= bus.I_fs;
      bufn_upd <= commit;
      timeout  <= expire;

      if (wd_clr) begin
        watchdog <= '0;
      end else if (state == S_WAIT_DONE) begin
        watchdog <= watchdog + 1'b1;
      end

      if (commit) begin
        bufn      <= (bufn == BUF_LAST) ? '0 : bufn + 8'd1;
        frame_cnt <= frame_cnt + 16'd1;
      end

      if (ovr_hit && (ovr_cnt != '1)) begin
        ovr_cnt <= ovr_cnt + 16'd1;
      end
    end
  end

  assign bus.O_wr_req    = (state == S_REQ);
  assign bus.O_bufn      = bufn;
  assign bus.O_bufn_upd  = bufn_upd;
  assign bus.O_frame_cnt = frame_cnt;
  assign bus.O_ovr_cnt   = ovr_cnt;
  assign bus.O_timeout   = timeout;

  a_bufn_range: assert property (@(posedge I_clk) disable iff (!I_rstn) bufn <= BUF_LAST);
  a_upd_timeout_excl: assert property (@(posedge I_clk) disable iff (!I_rstn) !(bufn_upd && timeout));

endmodule
